// File: rtl/simple_timer_pkg.sv
// Shared constants and state encoding for the timer snapshot reader.
// Holds the AXI response codes, the count register offsets and the reader FSM states.
package simple_timer_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [11:0] COUNT_LO_OFFSET = 12'h000;
    localparam logic [11:0] COUNT_HI_OFFSET = 12'h004;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI1,
        RD_LO,
        RD_HI2,
        RD_LO2,
        DONE
    } reader_state_t;

    // Anything other than OKAY, EXOKAY included, is a failed count read.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_single_reader.sv
// Single-outstanding AXI4-Lite read engine: one start issues one AR, then waits for R.
// AXI outputs come straight from flops; done/data/resp are the raw R-channel handshake.
module axi_lite_single_reader #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] addr_i,
    output logic          done_o,
    output logic [DW-1:0] data_o,
    output logic [1:0]    resp_o,
    output logic [AW-1:0] m_axi_araddr,
    output logic [2:0]    m_axi_arprot,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [DW-1:0] m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);

    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic [AW-1:0] araddr_q, araddr_d;

    always_comb begin
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        if (arvalid_q && m_axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
        end
        if (rready_q && m_axi_rvalid) begin
            rready_d = 1'b0;
        end
        // The caller only starts once the previous R handshake is done.
        if (start_i) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    assign done_o = rready_q & m_axi_rvalid;
    assign data_o = m_axi_rdata;
    assign resp_o = m_axi_rresp;

endmodule

// File: rtl/timer_snapshot_reader.sv
// Reads the 64-bit timer count as hi-lo-hi over AXI4-Lite and publishes a torn-free snapshot.
// A hi mismatch means lo rolled over between reads, so lo is re-read against the second hi.
module timer_snapshot_reader
    import simple_timer_pkg::*;
#(
    parameter logic [11:0] count_addr    = 12'h010,
    parameter logic [31:0] poll_interval = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    output logic        busy,
    output logic        snapshot_valid,
    output logic        snapshot_err,
    output logic [63:0] snapshot,
    output logic [11:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam logic [11:0] ADDR_LO = count_addr + COUNT_LO_OFFSET;
    localparam logic [11:0] ADDR_HI = count_addr + COUNT_HI_OFFSET;

    reader_state_t state_q, state_d;
    logic          pending_q, pending_d;
    logic [31:0]   poll_cnt_q, poll_cnt_d;
    logic [31:0]   h1_q, h1_d, l_q, l_d, h2_q, h2_d;
    logic [63:0]   snapshot_q, snapshot_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          rd_start;
    logic [11:0]   rd_addr;
    logic          rd_done;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic          poll_hit;
    logic          req;

    axi_lite_single_reader #(.AW(12), .DW(32)) u_reader (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (rd_start),
        .addr_i        (rd_addr),
        .done_o        (rd_done),
        .data_o        (rd_data),
        .resp_o        (rd_resp),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    // Poll counter free-runs regardless of busy; interval 0 parks it at zero.
    always_comb begin
        poll_hit   = (poll_interval != 32'd0) && (poll_cnt_q == poll_interval - 32'd1);
        poll_cnt_d = (poll_interval == 32'd0 || poll_hit) ? 32'd0 : poll_cnt_q + 32'd1;
        req        = trigger | poll_hit;
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        h1_d       = h1_q;
        l_d        = l_q;
        h2_d       = h2_q;
        snapshot_d = snapshot_q;
        err_d      = 1'b0;
        rd_start   = 1'b0;
        rd_addr    = ADDR_HI;

        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d   = RD_HI1;
                    pending_d = 1'b0;
                    rd_start  = 1'b1;
                    rd_addr   = ADDR_HI;
                end
            end
            RD_HI1: begin
                if (rd_done) begin
                    h1_d     = rd_data;
                    state_d  = RD_LO;
                    rd_start = 1'b1;
                    rd_addr  = ADDR_LO;
                end
            end
            RD_LO: begin
                if (rd_done) begin
                    l_d      = rd_data;
                    state_d  = RD_HI2;
                    rd_start = 1'b1;
                    rd_addr  = ADDR_HI;
                end
            end
            RD_HI2: begin
                if (rd_done) begin
                    if (rd_data == h1_q) begin
                        snapshot_d = {h1_q, l_q};
                        state_d    = DONE;
                    end else begin
                        h2_d     = rd_data;
                        state_d  = RD_LO2;
                        rd_start = 1'b1;
                        rd_addr  = ADDR_LO;
                    end
                end
            end
            RD_LO2: begin
                if (rd_done) begin
                    snapshot_d = {h2_q, rd_data};
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A failed read aborts the sequence and leaves the last good snapshot in place.
        if (rd_done && resp_is_err(rd_resp)) begin
            state_d    = DONE;
            rd_start   = 1'b0;
            snapshot_d = snapshot_q;
            err_d      = 1'b1;
        end

        if (state_q != IDLE && req) begin
            pending_d = 1'b1;
        end

        valid_d = (state_d == DONE);
        busy_d  = (state_d == RD_HI1) || (state_d == RD_LO) ||
                  (state_d == RD_HI2) || (state_d == RD_LO2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            poll_cnt_q <= 32'd0;
            h1_q       <= 32'd0;
            l_q        <= 32'd0;
            h2_q       <= 32'd0;
            snapshot_q <= 64'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            poll_cnt_q <= poll_cnt_d;
            h1_q       <= h1_d;
            l_q        <= l_d;
            h2_q       <= h2_d;
            snapshot_q <= snapshot_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign snapshot_valid = valid_q;
    assign snapshot_err   = err_q;
    assign snapshot       = snapshot_q;

endmodule

// File: tb/tb_timer_snapshot_reader.sv
// Directed bench for timer_snapshot_reader: scripted AXI slave, vector table, corner sequences.
// A second instance with a 100-cycle poll interval covers polling and mid-read reset.
module tb_timer_snapshot_reader;
    import simple_timer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: trigger-driven, scripted slave
    logic        rst_n, trigger, busy, snapshot_valid, snapshot_err;
    logic [63:0] snapshot;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    // Instance 2: poll-driven, fixed zero-wait slave
    logic        rst2_n, trigger2, busy2, valid2, err2;
    logic [63:0] snapshot2;
    logic [11:0] araddr2;
    logic [2:0]  arprot2;
    logic        arvalid2, arready2, rvalid2, rready2;
    logic [31:0] rdata2;
    logic [1:0]  rresp2;

    timer_snapshot_reader dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .busy(busy),
        .snapshot_valid(snapshot_valid), .snapshot_err(snapshot_err), .snapshot(snapshot),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    timer_snapshot_reader #(.count_addr(12'h010), .poll_interval(32'd100)) dut_poll (
        .clk(clk), .rst_n(rst2_n), .trigger(trigger2), .busy(busy2),
        .snapshot_valid(valid2), .snapshot_err(err2), .snapshot(snapshot2),
        .m_axi_araddr(araddr2), .m_axi_arprot(arprot2), .m_axi_arvalid(arvalid2),
        .m_axi_arready(arready2), .m_axi_rdata(rdata2), .m_axi_rresp(rresp2),
        .m_axi_rvalid(rvalid2), .m_axi_rready(rready2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scripted slave state: queued responses first, otherwise the stable count value.
    int          ar_wait = 0;
    int          r_wait  = 0;
    logic [63:0] cnt_val = 64'd0;
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [11:0] addr_log[$];
    int          viol = 0;
    int          rready_drop = 0;

    initial begin : slave1
        logic        ar_hs, r_hs, ar_seen, pend, r_out;
        logic [11:0] ar_addr, cap_addr;
        int          held, r_dly;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
        ar_seen = 1'b0; pend = 1'b0; r_out = 1'b0; held = 0; r_dly = 0;
        ar_addr = '0; cap_addr = '0;
        forever begin
            @(posedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            @(negedge clk);
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; ar_seen = 1'b0;
                pend = 1'b0; r_out = 1'b0; held = 0;
                continue;
            end
            if (r_hs) begin rvalid = 1'b0; r_out = 1'b0; end
            if (ar_hs) begin
                arready = 1'b0; ar_seen = 1'b0; held = 0;
                addr_log.push_back(ar_addr);
                cap_addr = ar_addr; pend = 1'b1; r_out = 1'b1; r_dly = r_wait;
            end
            if (pend) begin
                if (r_dly == 0) begin
                    rvalid = 1'b1; pend = 1'b0;
                    if (rq_data.size() > 0) begin
                        rdata = rq_data.pop_front();
                        rresp = rq_resp.pop_front();
                    end else begin
                        rdata = (cap_addr == 12'h014) ? cnt_val[63:32] : cnt_val[31:0];
                        rresp = RESP_OKAY;
                    end
                end else begin
                    r_dly--;
                end
            end
            if (r_out && !rready) rready_drop++;
            if (arvalid) begin
                if (!ar_seen) begin ar_seen = 1'b1; ar_addr = araddr; end
                else if (araddr !== ar_addr) viol++;
                if (held >= ar_wait) arready = 1'b1;
                else held++;
            end else if (ar_seen) begin
                viol++; ar_seen = 1'b0; held = 0;
            end
        end
    end

    initial begin : slave2
        logic a_hs, r_hs;
        arready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0; rresp2 = RESP_OKAY;
        forever begin
            @(posedge clk);
            a_hs = arvalid2 && arready2;
            r_hs = rvalid2 && rready2;
            @(negedge clk);
            if (!rst2_n) begin
                arready2 = 1'b0; rvalid2 = 1'b0;
            end else begin
                arready2 = 1'b1;
                if (r_hs) rvalid2 = 1'b0;
                if (a_hs) begin
                    rvalid2 = 1'b1;
                    rdata2  = (araddr2 == 12'h014) ? 32'h0000_0042 : 32'h0000_0099;
                end
            end
        end
    end

    typedef struct {
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
        int               nrd;
        logic [63:0]      snap;
        logic             err;
        int               lat;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] d0, d1, d2, d3,
                                input logic [1:0] r0, r1, r2, r3,
                                input int nrd, input logic [63:0] snap,
                                input logic err, input int lat);
        vec_t v;
        v.d = {d3, d2, d1, d0};
        v.r = {r3, r2, r1, r0};
        v.nrd = nrd; v.snap = snap; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic wait_valid(input int maxc, output int lat);
        lat = -1;
        for (int k = 1; k <= maxc; k++) begin
            if (snapshot_valid) begin lat = k; return; end
            @(negedge clk);
        end
    endtask

    initial begin : main
        vec_t        vt[9];
        int          lat, nv, n;
        int          vcyc[4];
        logic        b1, busy8, busy9, addr_ok;
        logic [63:0] O = 64'd0;

        vt[0] = mk(32'h1, 32'hFFFF_FFF0, 32'h1, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0,
                   3, 64'h0000_0001_FFFF_FFF0, 1'b0, 7);
        vt[1] = mk(32'h1, 32'h2, 32'h2, 32'h5, 2'd0, 2'd0, 2'd0, 2'd0,
                   4, 64'h0000_0002_0000_0005, 1'b0, 9);
        vt[2] = mk(32'h7, 32'h8, 32'h0, 32'h0, 2'd0, RESP_SLVERR, 2'd0, 2'd0,
                   2, 64'h0000_0002_0000_0005, 1'b1, 5);
        vt[3] = mk(32'h9, 32'h0, 32'h0, 32'h0, RESP_DECERR, 2'd0, 2'd0, 2'd0,
                   1, 64'h0000_0002_0000_0005, 1'b1, 3);
        vt[4] = mk(32'h3, 32'hAAAA_0000, 32'h3, 32'h0, 2'd0, 2'd0, RESP_SLVERR, 2'd0,
                   3, 64'h0000_0002_0000_0005, 1'b1, 7);
        vt[5] = mk(32'h3, 32'h1, 32'h4, 32'h6, 2'd0, 2'd0, 2'd0, RESP_SLVERR,
                   4, 64'h0000_0002_0000_0005, 1'b1, 9);
        vt[6] = mk(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0,
                   3, 64'hFFFF_FFFF_0000_0000, 1'b0, 7);
        vt[7] = mk(32'h3, 32'h5, 32'h0, 32'h0, 2'd0, RESP_EXOKAY, 2'd0, 2'd0,
                   2, 64'hFFFF_FFFF_0000_0000, 1'b1, 5);
        vt[8] = mk(32'h10, 32'hFFFF_FFFF, 32'h11, 32'h3, 2'd0, 2'd0, 2'd0, 2'd0,
                   4, 64'h0000_0011_0000_0003, 1'b0, 9);

        rst_n = 1'b0; rst2_n = 1'b0; trigger = 1'b0; trigger2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, O);
        chk("rst_valid", {63'd0, snapshot_valid}, O);
        chk("rst_err", {63'd0, snapshot_err}, O);
        chk("rst_snapshot", snapshot, O);
        chk("rst_arvalid", {63'd0, arvalid}, O);
        chk("rst_rready", {63'd0, rready}, O);
        chk("rst_araddr", {52'd0, araddr}, O);
        chk("rst_arprot", {61'd0, arprot}, O);
        chk("rst2_busy", {63'd0, busy2}, O);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: one triggered sequence per vector against queued slave responses
        for (int v = 0; v < 9; v++) begin
            addr_log.delete();
            for (int i = 0; i < vt[v].nrd; i++) begin
                rq_data.push_back(vt[v].d[i]);
                rq_resp.push_back(vt[v].r[i]);
            end
            trigger = 1'b1;
            @(negedge clk);
            trigger = 1'b0;
            b1 = busy;
            wait_valid(50, lat);
            chk($sformatf("v%0d_busy_T1", v), {63'd0, b1}, 64'd1);
            chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
            chk($sformatf("v%0d_snapshot", v), snapshot, vt[v].snap);
            chk($sformatf("v%0d_err", v), {63'd0, snapshot_err}, {63'd0, vt[v].err});
            chk($sformatf("v%0d_busy_done", v), {63'd0, busy}, O);
            chk($sformatf("v%0d_num_ar", v), addr_log.size(), vt[v].nrd);
            addr_ok = 1'b1;
            foreach (addr_log[i])
                if (addr_log[i] !== ((i % 2 == 0) ? 12'h014 : 12'h010)) addr_ok = 1'b0;
            chk($sformatf("v%0d_addr_order", v), {63'd0, addr_ok}, 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_valid_pulse", v), {63'd0, snapshot_valid}, O);
            chk($sformatf("v%0d_busy_after", v), {63'd0, busy}, O);
            rq_data.delete(); rq_resp.delete();
            repeat (2) @(negedge clk);
        end

        // Slow slave: AR stalls 5 cycles, R arrives 3 cycles late
        ar_wait = 5; r_wait = 3; viol = 0; rready_drop = 0;
        cnt_val = 64'hA5A5_0003_1234_5678;
        addr_log.delete();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_valid(200, lat);
        chk("slow_valid_seen", {63'd0, lat > 0}, 64'd1);
        chk("slow_snapshot", snapshot, 64'hA5A5_0003_1234_5678);
        chk("slow_err", {63'd0, snapshot_err}, O);
        chk("slow_ar_stable", viol, 0);
        chk("slow_rready_held", rready_drop, 0);
        chk("slow_num_ar", addr_log.size(), 3);
        ar_wait = 0; r_wait = 0;
        repeat (3) @(negedge clk);

        // Three triggers while busy coalesce into one follow-up sequence
        cnt_val = 64'h0000_0000_0000_1111;
        nv = 0; busy8 = 1'b0; busy9 = 1'b0;
        for (int i = 0; i < 4; i++) vcyc[i] = 0;
        trigger = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            trigger = (k == 2 || k == 4 || k == 6);
            if (snapshot_valid) begin
                if (nv < 4) vcyc[nv] = k;
                nv++;
            end
            if (k == 8) busy8 = busy;
            if (k == 9) busy9 = busy;
            @(negedge clk);
        end
        trigger = 1'b0;
        chk("coal_num_seq", nv, 2);
        chk("coal_first_valid", vcyc[0], 7);
        chk("coal_second_valid", vcyc[1], 15);
        chk("coal_idle_gap", {63'd0, busy8}, O);
        chk("coal_restart", {63'd0, busy9}, 64'd1);
        chk("coal_snapshot", snapshot, 64'h0000_0000_0000_1111);

        // Poll-driven instance: period, then reset during the RD_LO address phase
        rst2_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 4; i++) vcyc[i] = 0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (valid2) begin
                if (nv < 4) vcyc[nv] = k;
                nv++;
            end
        end
        chk("poll_count", nv, 2);
        chk("poll_first", vcyc[0], 106);
        chk("poll_period", vcyc[1] - vcyc[0], 100);
        chk("poll_snapshot", snapshot2, 64'h0000_0042_0000_0099);
        chk("poll_err", {63'd0, err2}, O);
        n = 0;
        while (!busy2 && n < 120) begin @(negedge clk); n++; end
        chk("poll_busy_seen", {63'd0, busy2}, 64'd1);
        repeat (2) @(negedge clk);
        chk("poll_rdlo_arvalid", {63'd0, arvalid2}, 64'd1);
        chk("poll_rdlo_araddr", {52'd0, araddr2}, 64'h010);
        rst2_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", {63'd0, arvalid2}, O);
        chk("mid_rst_rready", {63'd0, rready2}, O);
        chk("mid_rst_busy", {63'd0, busy2}, O);
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (valid2) begin lat = k; break; end
        end
        chk("post_rst_first_valid", lat, 106);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
